// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the regfile_2r1w register file.
// Holds the clear-sequencer state encoding and the default geometry.
package regfile_pkg;

   // Default geometry of the CPU register bank.
   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;

   // Bulk-clear sequencer states.
   //   CLR_IDLE  : waiting for a clear request, user writes allowed
   //   CLR_SWEEP : zeroing one register per cycle, user writes dropped
   //   CLR_DONE  : one-cycle completion pulse, user writes allowed again
   typedef enum logic [1:0] {
      CLR_IDLE  = 2'd0,
      CLR_SWEEP = 2'd1,
      CLR_DONE  = 2'd2
   } clr_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: bulk-clear sequencer for regfile_2r1w.
// Walks a pointer over every register, issuing one zero-write per cycle,
// then raises a single-cycle completion pulse. The current state is
// exported so checkers can observe the sequencer directly.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_done,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr,
   output clr_state_t    state
);

   // Pointer value of the final register swept.
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   clr_state_t    state_nxt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_nxt;

   // State and sweep-pointer registers; reset aborts any sweep silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLR_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next-state logic: requests are only sampled in IDLE, so a level held
   // through DONE naturally starts another sweep once IDLE is reached.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      unique case (state)
         CLR_IDLE: begin
            if (clr_req) begin
               state_nxt = CLR_SWEEP;
               ptr_nxt   = '0;
            end
         end
         CLR_SWEEP: begin
            if (ptr == LAST_PTR) begin
               state_nxt = CLR_DONE;
               ptr_nxt   = '0;
            end else begin
               ptr_nxt = ptr + 1'b1;
            end
         end
         CLR_DONE: begin
            state_nxt = CLR_IDLE;
         end
         default: begin
            state_nxt = CLR_IDLE;
            ptr_nxt   = '0;
         end
      endcase
   end

   // Moore outputs: the storage zero-write follows the sweep pointer.
   always_comb begin
      busy     = (state == CLR_SWEEP);
      clr_done = (state == CLR_DONE);
      clr_we   = (state == CLR_SWEEP);
      clr_addr = ptr;
   end

endmodule : regfile_clr_fsm

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file, one synchronous write port and
// two combinational read ports, optional hardwired-zero register 0 and a
// sequenced bulk-clear engine (regfile_clr_fsm).
//
// Handshake: a write is accepted on a rising edge when We && Wready.
// Wready is low only while a clear sweep runs; writes presented then are
// dropped, so the writer must keep We asserted until it sees Wready.
//
// Build option: define REGFILE_BYPASS_EN to forward an accepted user write
// to a read port addressing the same register in the same cycle. Without
// it, reads show the old value until the cycle after the write.
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = DEFAULT_WIDTH,
   parameter  int DEPTH    = DEFAULT_DEPTH,
   parameter  bit ZERO_REG = 1'b1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             We,
   input  logic [AW-1:0]    Waddr,
   input  logic [WIDTH-1:0] Wdata,
   output logic             Wready,
   input  logic [AW-1:0]    Raddr1,
   input  logic [AW-1:0]    Raddr2,
   output logic [WIDTH-1:0] Rdata1,
   output logic [WIDTH-1:0] Rdata2,
   input  logic             ClrReq,
   output logic             Busy,
   output logic             ClrDone
);

   // One extra bit so DEPTH itself is representable for range checks.
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             clr_busy;
   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   clr_state_t       clr_state;

   logic             waddr_ok;
   logic             raddr1_ok;
   logic             raddr2_ok;
   logic             user_wr;

   // An address is usable if it names a real register and is not the
   // hardwired zero register.
   function automatic logic addr_usable(input logic [AW-1:0] addr);
      logic in_range;
      logic is_zero;
      in_range = ({1'b0, addr} < DEPTH_W);
      is_zero  = ZERO_REG && (addr == '0);
      return in_range && !is_zero;
   endfunction

   regfile_clr_fsm #(
      .DEPTH (DEPTH)
   ) u_clr_fsm (
      .clk      (Clk),
      .rst      (Rst),
      .clr_req  (ClrReq),
      .busy     (clr_busy),
      .clr_done (ClrDone),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .state    (clr_state)
   );

   // Write acceptance: writes are blocked exactly while the sweep runs.
   always_comb begin
      Busy      = clr_busy;
      Wready    = (clr_state != CLR_SWEEP);
      waddr_ok  = addr_usable(Waddr);
      raddr1_ok = addr_usable(Raddr1);
      raddr2_ok = addr_usable(Raddr2);
      user_wr   = We && Wready && waddr_ok;
   end

   // Storage array. User writes and sweep zeroing never coincide because
   // user writes are refused while the sweep is active.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (user_wr) begin
            mem[Waddr] <= Wdata;
         end
         if (clr_we) begin
            mem[clr_addr] <= '0;
         end
      end
   end

   // Read port 1: out-of-range and zero-register reads return 0.
   always_comb begin
      Rdata1 = '0;
      if (raddr1_ok) begin
         Rdata1 = mem[Raddr1];
      end
`ifdef REGFILE_BYPASS_EN
      if (user_wr && (Waddr == Raddr1)) begin
         Rdata1 = Wdata;
      end
`endif
   end

   // Read port 2: identical behaviour to port 1.
   always_comb begin
      Rdata2 = '0;
      if (raddr2_ok) begin
         Rdata2 = mem[Raddr2];
      end
`ifdef REGFILE_BYPASS_EN
      if (user_wr && (Waddr == Raddr2)) begin
         Rdata2 = Wdata;
      end
`endif
   end

endmodule : regfile_2r1w
